// File: rtl/sprite_line_renderer_pkg.sv
// rtl/sprite_line_renderer_pkg.sv - shared video timing, sprite geometry and renderer FSM state type
package sprite_line_renderer_pkg;

   localparam logic [8:0] H_DISPLAY = 9'd256;
   localparam logic [8:0] H_MAX     = 9'd308;
   localparam logic [8:0] V_MAX     = 9'd261;

   localparam int SPR_W = 8;
   localparam int SPR_H = 16;
   localparam int ROW_W = $clog2(SPR_H);
   localparam int RGB_W = 3;

   localparam logic [RGB_W-1:0] BG_COLOR = 3'b000;

   typedef enum logic [2:0] {IDLE, CHECK, FETCH, ARMED, DRAW} state_t;

   // Scanline that follows v; the last line of a frame is followed by line 0.
   function automatic logic [8:0] next_line(input logic [8:0] v);
      return (v == V_MAX) ? 9'd0 : v + 9'd1;
   endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// rtl/sprite_row_shifter.sv - sprite line buffer, pixel shift register and pixel counter
module sprite_row_shifter
   import sprite_line_renderer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             buf_load,
   input  logic             buf_clear,
   input  logic [SPR_W-1:0] buf_data,
   input  logic             start,
   input  logic             abort,
   output logic             buf_valid,
   output logic             pixel,
   output logic             last
);

   localparam int CNT_W = $clog2(SPR_W + 1);

   logic [SPR_W-1:0] line_buf;
   logic [SPR_W-1:0] shift_reg;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_buf  <= '0;
         buf_valid <= 1'b0;
         shift_reg <= '0;
         count     <= '0;
      end else begin
         if (buf_load) begin
            line_buf  <= buf_data;
            buf_valid <= 1'b1;
         end else if (buf_clear) begin
            buf_valid <= 1'b0;
         end
         // The leftmost pixel is emitted straight from the buffer on the start
         // cycle, so the shifter holds only the remaining SPR_W-1 pixels.
         if (start) begin
            shift_reg <= {line_buf[SPR_W-2:0], 1'b0};
            count     <= CNT_W'(SPR_W - 1);
         end else if (abort) begin
            shift_reg <= '0;
            count     <= '0;
         end else if (count != '0) begin
            shift_reg <= {shift_reg[SPR_W-2:0], 1'b0};
            count     <= count - CNT_W'(1);
         end
      end
   end

   assign pixel = start ? line_buf[SPR_W-1] : ((count != '0) & shift_reg[SPR_W-1]);
   assign last  = (count == CNT_W'(1));

endmodule

// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - fetches one 8x16 sprite row per blank and draws it on the next line
module sprite_line_renderer
   import sprite_line_renderer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [8:0]       hpos,
   input  logic [8:0]       vpos,
   input  logic             display_on,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic [8:0]       sprite_x,
   input  logic [8:0]       sprite_y,
   input  logic [RGB_W-1:0] sprite_color,
   output logic             rom_req,
   output logic [ROW_W-1:0] rom_addr,
   input  logic             rom_valid,
   input  logic [SPR_W-1:0] rom_bits,
   output logic [RGB_W-1:0] rgb,
   output logic             hsync,
   output logic             vsync
);

   state_t           state;
   logic [8:0]       latched_x;
   logic [RGB_W-1:0] latched_color;
   logic [8:0]       row;
   logic             in_range;
   logic             start;
   logic             abort;
   logic             buf_load;
   logic             buf_clear;
   logic             buf_valid;
   logic             pixel;
   logic             last;
   logic             pixel_active;

   // Negative offsets wrap to large values and fall out of range.
   assign row       = next_line(vpos) - sprite_y;
   assign in_range  = (row < 9'(SPR_H));
   assign start     = (state == ARMED) && display_on && (hpos == latched_x) && buf_valid;
   assign abort     = (state == DRAW) && (hpos == H_DISPLAY);
   assign buf_load  = (state == FETCH) && rom_valid;
   assign buf_clear = ((state == CHECK) && !in_range) ||
                      ((state == FETCH) && !rom_valid && (hpos == H_MAX));
   assign pixel_active = (start || (state == DRAW)) && pixel;

   sprite_row_shifter u_shifter (
      .clk       (clk),
      .rst       (reset),
      .buf_load  (buf_load),
      .buf_clear (buf_clear),
      .buf_data  (rom_bits),
      .start     (start),
      .abort     (abort),
      .buf_valid (buf_valid),
      .pixel     (pixel),
      .last      (last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rom_req       <= 1'b0;
         rom_addr      <= '0;
         latched_x     <= '0;
         latched_color <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hpos == H_DISPLAY) state <= CHECK;
            end
            CHECK: begin
               latched_x     <= sprite_x;
               latched_color <= sprite_color;
               if (in_range) begin
                  rom_addr <= row[ROW_W-1:0];
                  rom_req  <= 1'b1;
                  state    <= FETCH;
               end else begin
                  state <= IDLE;
               end
            end
            FETCH: begin
               if (rom_valid) begin
                  rom_req <= 1'b0;
                  state   <= ARMED;
               end else if (hpos == H_MAX) begin
                  rom_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            ARMED: begin
               if (start) state <= DRAW;
               else if (hpos == H_DISPLAY) state <= CHECK;
            end
            DRAW: begin
               // Right-edge clipping: the blank has begun, so go fetch the next row.
               if (abort) state <= CHECK;
               else if (last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb   <= '0;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         rgb   <= !display_on ? '0 : (pixel_active ? latched_color : BG_COLOR);
         hsync <= hsync_in;
         vsync <= vsync_in;
      end
   end

endmodule
